fu_issue_sched: RTL and testbench

FU_ISSUE_SCHED -- requirements
Module: fu_issue_sched

---
 rtl/fu_issue_sched.sv | 152 +++++++++++++++
 tb/tb_fu_issue_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_sched.sv
// Per-FU-class issue queues (alu/ls/mult/branch) fed by three RS slots; optional bypass via FU_ISSUE_BYPASS_EN.
// Latency: one cycle from push to head (zero with FU_ISSUE_BYPASS_EN on an empty queue).
// Backpressure: registered per-class stall when free < 3; excess pushes drop and set sticky fu_overflow.
package fu_issue_sched_pkg;
   localparam logic [2:0] FU_NONE = 3'd0;
   localparam logic [2:0] ALU_1   = 3'd1;
   localparam logic [2:0] LS_1    = 3'd2;
   localparam logic [2:0] MULT_1  = 3'd3;
   localparam logic [2:0] BRANCH  = 3'd4;

   typedef struct packed {
      logic        valid;
      logic [2:0]  dec_fu_unit_sel;
      logic [15:0] tag;
   } RS_S_PACKET;

   typedef struct packed {
      logic alu;
      logic ls;
      logic mult;
      logic branch;
   } FU_FIFO_PACKET;
endpackage

module fu_issue_sched
   import fu_issue_sched_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  RS_S_PACKET [2:0]                     rs_issue_pkts,
   input  logic                                 squash,
   input  logic [3:0]                           fu_ready,
   output RS_S_PACKET [3:0]                     fu_pkts,
   output FU_FIFO_PACKET                        fu_fifo_stall,
   output logic [3:0][$clog2(DEPTH+1)-1:0]      fu_count,
   output logic                                 fu_overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic [2:0] class_sel(input int c);
      case (c)
         0:       class_sel = ALU_1;
         1:       class_sel = LS_1;
         2:       class_sel = MULT_1;
         default: class_sel = BRANCH;
      endcase
   endfunction

   RS_S_PACKET    mem_q   [4][DEPTH];
   RS_S_PACKET    mem_d   [4][DEPTH];
   logic [PW-1:0] head_q  [4];
   logic [PW-1:0] head_d  [4];
   logic [PW-1:0] tail_q  [4];
   logic [PW-1:0] tail_d  [4];
   logic [CW-1:0] count_q [4];
   logic [CW-1:0] count_d [4];
   logic          overflow_q;
   logic          overflow_d;

   logic          pop;
   logic          wr;
   logic          byp_open;
   logic [CW-1:0] free;
   logic [CW-1:0] n_wr;
   logic [3:0]    stall;

   always_comb begin
      mem_d      = mem_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      fu_pkts    = '0;
      pop        = 1'b0;
      wr         = 1'b0;
      byp_open   = 1'b0;
      free       = '0;
      n_wr       = '0;
      for (int c = 0; c < 4; c++) begin
         fu_pkts[c]       = mem_q[c][head_q[c]];
         fu_pkts[c].valid = (count_q[c] != '0) && !squash;
         pop              = fu_pkts[c].valid && fu_ready[c];
         free             = CW'(DEPTH) - count_q[c] + CW'(pop);
         n_wr             = '0;
         byp_open         = 1'b0;
`ifdef FU_ISSUE_BYPASS_EN
         // Reset gates the bypass so fu_pkts stays quiet while rst is low.
         byp_open         = (count_q[c] == '0) && !squash && rst;
`endif
         for (int s = 2; s >= 0; s--) begin
            if (rs_issue_pkts[s].valid && !squash &&
                rs_issue_pkts[s].dec_fu_unit_sel == class_sel(c)) begin
               wr = 1'b1;
               if (byp_open) begin
                  byp_open   = 1'b0;
                  fu_pkts[c] = rs_issue_pkts[s];
                  wr         = !fu_ready[c];
               end
               if (wr) begin
                  if (n_wr < free) begin
                     mem_d[c][tail_q[c] + PW'(n_wr)] = rs_issue_pkts[s];
                     n_wr = n_wr + CW'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end
         head_d[c]  = head_q[c] + PW'(pop);
         tail_d[c]  = tail_q[c] + PW'(n_wr);
         count_d[c] = count_q[c] + n_wr - CW'(pop);
         if (squash) begin
            head_d[c]  = '0;
            tail_d[c]  = '0;
            count_d[c] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            head_q[c]  <= '0;
            tail_q[c]  <= '0;
            count_q[c] <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
         end
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         fu_count[c] = count_q[c];
         stall[c]    = (CW'(DEPTH) - count_q[c]) < CW'(3);
      end
      fu_fifo_stall.alu    = stall[0];
      fu_fifo_stall.ls     = stall[1];
      fu_fifo_stall.mult   = stall[2];
      fu_fifo_stall.branch = stall[3];
      fu_overflow          = overflow_q;
   end
endmodule

// File: tb/tb_fu_issue_sched.sv
// Directed vector bench for fu_issue_sched (DEPTH=8); expectations adapt to FU_ISSUE_BYPASS_EN.
module tb_fu_issue_sched;
   import fu_issue_sched_pkg::*;

`ifdef FU_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   RS_S_PACKET [2:0]   rs_issue_pkts;
   logic               squash;
   logic [3:0]         fu_ready;
   RS_S_PACKET [3:0]   fu_pkts;
   FU_FIFO_PACKET      fu_fifo_stall;
   logic [3:0][3:0]    fu_count;
   logic               fu_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   fu_issue_sched #(.DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .rs_issue_pkts (rs_issue_pkts),
      .squash        (squash),
      .fu_ready      (fu_ready),
      .fu_pkts       (fu_pkts),
      .fu_fifo_stall (fu_fifo_stall),
      .fu_count      (fu_count),
      .fu_overflow   (fu_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      RS_S_PACKET  s2, s1, s0;
      logic        sq;
      logic [3:0]  rdy;
      logic [3:0]  vnb, vby;
      logic [15:0] t0, t1, t2, t3;
      logic [3:0]  c0, c1, c2, c3;
      logic [3:0]  stall;
      logic        ovf;
   } vec_t;

   vec_t tbl [20];

   function automatic RS_S_PACKET mk(input logic [2:0] sel, input logic [15:0] tag);
      RS_S_PACKET p;
      p.valid = 1'b1;
      p.dec_fu_unit_sel = sel;
      p.tag = tag;
      return p;
   endfunction

   function automatic vec_t row(input RS_S_PACKET s2, s1, s0, input logic sq, input logic [3:0] rdy,
                                input logic [3:0] vnb, vby, input logic [15:0] t0, t1, t2, t3,
                                input logic [3:0] c0, c1, c2, c3, input logic [3:0] stall, input logic ovf);
      vec_t v;
      v.s2 = s2; v.s1 = s1; v.s0 = s0; v.sq = sq; v.rdy = rdy;
      v.vnb = vnb; v.vby = vby; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
      v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3; v.stall = stall; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] vld_vec();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = fu_pkts[c].valid;
      return v;
   endfunction

   function automatic logic [3:0] stall_vec();
      return {fu_fifo_stall.branch, fu_fifo_stall.mult, fu_fifo_stall.ls, fu_fifo_stall.alu};
   endfunction

   task automatic apply_row(input int i, input vec_t v);
      logic [3:0]  ev;
      logic [15:0] et [4];
      @(negedge clk);
      rs_issue_pkts[2] = v.s2;
      rs_issue_pkts[1] = v.s1;
      rs_issue_pkts[0] = v.s0;
      squash = v.sq;
      fu_ready = v.rdy;
      #1;
      ev = BYP ? v.vby : v.vnb;
      et[0] = v.t0; et[1] = v.t1; et[2] = v.t2; et[3] = v.t3;
      chk($sformatf("row%0d valid", i), 32'(vld_vec()), 32'(ev));
      for (int c = 0; c < 4; c++)
         if (ev[c]) chk($sformatf("row%0d tag%0d", i, c), 32'(fu_pkts[c].tag), 32'(et[c]));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d count", i), 32'(fu_count), 32'({v.c3, v.c2, v.c1, v.c0}));
      chk($sformatf("row%0d stall", i), 32'(stall_vec()), 32'(v.stall));
      chk($sformatf("row%0d ovf", i), 32'(fu_overflow), 32'(v.ovf));
   endtask

   initial begin
      RS_S_PACKET np, bad0, bad7, inv;
      np = '0;
      bad0 = mk(FU_NONE, 16'h70);
      bad7 = mk(3'd7, 16'h71);
      inv = mk(ALU_1, 16'h72);
      inv.valid = 1'b0;

      //           s2                s1                s0                sq  rdy      vnb      vby      t0     t1     t2     t3     c0 c1 c2 c3 stall    ovf
      tbl[0]  = row(np,               np,               np,               0, 4'b0000, 4'b0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 0);
      tbl[1]  = row(mk(ALU_1,'hA),    mk(ALU_1,'hB),    mk(ALU_1,'hC),    0, 4'b0000, 4'b0000, 4'b0001, 16'hA, 16'h0, 16'h0, 16'h0, 3, 0, 0, 0, 4'b0000, 0);
      tbl[2]  = row(np,               np,               np,               0, 4'b0001, 4'b0001, 4'b0001, 16'hA, 16'h0, 16'h0, 16'h0, 2, 0, 0, 0, 4'b0000, 0);
      tbl[3]  = row(np,               np,               np,               0, 4'b0001, 4'b0001, 4'b0001, 16'hB, 16'h0, 16'h0, 16'h0, 1, 0, 0, 0, 4'b0000, 0);
      tbl[4]  = row(np,               np,               np,               0, 4'b0001, 4'b0001, 4'b0001, 16'hC, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 0);
      tbl[5]  = row(np,               np,               np,               0, 4'b0001, 4'b0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 0);
      tbl[6]  = row(mk(LS_1,'h10),    mk(LS_1,'h11),    mk(LS_1,'h12),    0, 4'b0000, 4'b0000, 4'b0010, 16'h0, 16'h10, 16'h0, 16'h0, 0, 3, 0, 0, 4'b0000, 0);
      tbl[7]  = row(mk(LS_1,'h13),    mk(LS_1,'h14),    mk(LS_1,'h15),    0, 4'b0000, 4'b0010, 4'b0010, 16'h0, 16'h10, 16'h0, 16'h0, 0, 6, 0, 0, 4'b0010, 0);
      tbl[8]  = row(np,               np,               np,               0, 4'b0010, 4'b0010, 4'b0010, 16'h0, 16'h10, 16'h0, 16'h0, 0, 5, 0, 0, 4'b0000, 0);
      tbl[9]  = row(mk(LS_1,'h16),    mk(LS_1,'h17),    np,               0, 4'b0000, 4'b0010, 4'b0010, 16'h0, 16'h11, 16'h0, 16'h0, 0, 7, 0, 0, 4'b0010, 0);
      tbl[10] = row(mk(LS_1,'h18),    mk(LS_1,'h19),    mk(LS_1,'h1A),    0, 4'b0000, 4'b0010, 4'b0010, 16'h0, 16'h11, 16'h0, 16'h0, 0, 8, 0, 0, 4'b0010, 1);
      tbl[11] = row(np,               np,               np,               0, 4'b0000, 4'b0010, 4'b0010, 16'h0, 16'h11, 16'h0, 16'h0, 0, 8, 0, 0, 4'b0010, 1);
      tbl[12] = row(mk(LS_1,'h1B),    mk(LS_1,'h1C),    mk(LS_1,'h1D),    0, 4'b0010, 4'b0010, 4'b0010, 16'h0, 16'h11, 16'h0, 16'h0, 0, 8, 0, 0, 4'b0010, 1);
      tbl[13] = row(mk(ALU_1,'h20),   mk(MULT_1,'h30),  mk(BRANCH,'h40),  0, 4'b0010, 4'b0010, 4'b1111, 16'h20, 16'h12, 16'h30, 16'h40, 1, 7, 1, 1, 4'b0010, 1);
      tbl[14] = row(mk(ALU_1,'h21),   mk(MULT_1,'h31),  mk(BRANCH,'h42),  0, 4'b0010, 4'b1111, 4'b1111, 16'h20, 16'h13, 16'h30, 16'h40, 2, 6, 2, 2, 4'b0010, 1);
      tbl[15] = row(mk(ALU_1,'h22),   mk(ALU_1,'h23),   mk(MULT_1,'h32),  0, 4'b0010, 4'b1111, 4'b1111, 16'h20, 16'h14, 16'h30, 16'h40, 4, 5, 3, 2, 4'b0000, 1);
      tbl[16] = row(mk(MULT_1,'h33),  mk(BRANCH,'h43),  mk(BRANCH,'h44),  0, 4'b0010, 4'b1111, 4'b1111, 16'h20, 16'h15, 16'h30, 16'h40, 4, 4, 4, 4, 4'b0000, 1);
      tbl[17] = row(mk(ALU_1,'h50),   mk(LS_1,'h51),    mk(MULT_1,'h52),  1, 4'b1111, 4'b0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 1);
      tbl[18] = row(np,               np,               np,               0, 4'b1111, 4'b0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 1);
      tbl[19] = row(bad0,             bad7,             inv,              0, 4'b0000, 4'b0000, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'b0000, 1);

      rst = 1'b1;
      rs_issue_pkts = '0;
      squash = 1'b0;
      fu_ready = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset count", 32'(fu_count), 32'h0);
      chk("reset valid", 32'(vld_vec()), 32'h0);
      chk("reset stall", 32'(stall_vec()), 32'h0);
      chk("reset ovf", 32'(fu_overflow), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) apply_row(i, tbl[i]);

      // One MULT push into an empty queue with the FU ready.
      @(negedge clk);
      rs_issue_pkts = '0;
      rs_issue_pkts[0] = mk(MULT_1, 16'h60);
      fu_ready = 4'b0100;
      #1;
`ifdef FU_ISSUE_BYPASS_EN
      chk("byp same-cycle valid", 32'(fu_pkts[2].valid), 32'h1);
      chk("byp same-cycle tag", 32'(fu_pkts[2].tag), 32'h60);
`else
      chk("nobyp same-cycle valid", 32'(fu_pkts[2].valid), 32'h0);
`endif
      @(posedge clk);
      #1;
      chk("mult count after push", 32'(fu_count[2]), BYP ? 32'h0 : 32'h1);
      @(negedge clk);
      rs_issue_pkts = '0;
      #1;
      chk("mult next-cycle valid", 32'(fu_pkts[2].valid), BYP ? 32'h0 : 32'h1);
`ifndef FU_ISSUE_BYPASS_EN
      chk("mult next-cycle tag", 32'(fu_pkts[2].tag), 32'h60);
`endif
      @(posedge clk);
      #1;
      chk("mult count drained", 32'(fu_count[2]), 32'h0);

      // Reset asserted with queued packets and sticky overflow set.
      @(negedge clk);
      rs_issue_pkts[2] = mk(ALU_1, 16'h81);
      rs_issue_pkts[1] = mk(ALU_1, 16'h82);
      rs_issue_pkts[0] = mk(ALU_1, 16'h83);
      fu_ready = 4'b0000;
      @(posedge clk);
      #1;
      chk("pre-reset alu count", 32'(fu_count[0]), 32'h3);
      @(negedge clk);
      rs_issue_pkts = '0;
      rs_issue_pkts[0] = mk(LS_1, 16'h84);
      #1 rst = 1'b0;
      #1;
      chk("midrst count", 32'(fu_count), 32'h0);
      chk("midrst valid", 32'(vld_vec()), 32'h0);
      chk("midrst stall", 32'(stall_vec()), 32'h0);
      chk("midrst ovf", 32'(fu_overflow), 32'h0);
      @(negedge clk);
      rs_issue_pkts = '0;
      fu_ready = 4'b1111;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset count", 32'(fu_count), 32'h0);
      chk("post-reset valid", 32'(vld_vec()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
